// File: rtl/gc_trap_controller_pkg.sv
// Shared types for the global-control trap sequencer: FSM states, pending-event kinds
// and the trap packet handed to csr_regs.
package gc_trap_controller_pkg;

  localparam int GC_XLEN   = 32;
  localparam int GC_ID_W   = 3;
  localparam int GC_CODE_W = 5;

  typedef enum logic [2:0] {
    GC_INIT_CLEAR,
    GC_IDLE,
    GC_WAIT_IDLE,
    GC_TLB_CLEAR,
    GC_FLUSH,
    GC_REDIRECT
  } gc_trap_state_t;

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_FENCE_I,
    PEND_SFENCE,
    PEND_INTERRUPT
  } gc_pending_t;

  typedef struct packed {
    logic [GC_CODE_W-1:0] code;
    logic [GC_XLEN-1:0]   tval;
    logic [GC_ID_W-1:0]   id;
    logic                 is_interrupt;
  } trap_packet_t;

endpackage

// File: rtl/gc_trap_controller_if.sv
// Bundle of exception/event inputs and fetch/issue/CSR controls around the trap sequencer.
// master = the sequencer, slave = the pipeline and CSR side.
interface gc_trap_controller_if #(
  parameter int NUM_SRC = 4,
  parameter int XLEN    = 32,
  parameter int ID_W    = 3,
  parameter int CODE_W  = 5
);
  logic [NUM_SRC-1:0]        exc_valid;
  logic [NUM_SRC*CODE_W-1:0] exc_code;
  logic [NUM_SRC*XLEN-1:0]   exc_tval;
  logic [NUM_SRC*ID_W-1:0]   exc_id;
  logic                      interrupt_pending;
  logic [CODE_W-1:0]         interrupt_code;
  logic [XLEN-1:0]           interrupt_pc;
  logic                      pipeline_idle;
  logic                      ret_req;
  logic [XLEN-1:0]           ret_pc;
  logic                      fence_i_req;
  logic                      sfence_req;
  logic [XLEN-1:0]           sys_pc;
  logic [XLEN-1:0]           trap_vector;

  logic                      trap_valid;
  logic                      trap_is_interrupt;
  logic [CODE_W-1:0]         trap_code;
  logic [XLEN-1:0]           trap_tval;
  logic [ID_W-1:0]           trap_id;
  logic                      fetch_hold;
  logic                      issue_hold;
  logic                      fetch_flush;
  logic                      fetch_pc_override;
  logic [XLEN-1:0]           fetch_pc;
  logic                      init_clear;
  logic                      tlb_clear;
  logic                      idle;

  modport master (
    input  exc_valid, exc_code, exc_tval, exc_id, interrupt_pending, interrupt_code,
           interrupt_pc, pipeline_idle, ret_req, ret_pc, fence_i_req, sfence_req,
           sys_pc, trap_vector,
    output trap_valid, trap_is_interrupt, trap_code, trap_tval, trap_id, fetch_hold,
           issue_hold, fetch_flush, fetch_pc_override, fetch_pc, init_clear, tlb_clear, idle
  );

  modport slave (
    output exc_valid, exc_code, exc_tval, exc_id, interrupt_pending, interrupt_code,
           interrupt_pc, pipeline_idle, ret_req, ret_pc, fence_i_req, sfence_req,
           sys_pc, trap_vector,
    input  trap_valid, trap_is_interrupt, trap_code, trap_tval, trap_id, fetch_hold,
           issue_hold, fetch_flush, fetch_pc_override, fetch_pc, init_clear, tlb_clear, idle
  );
endinterface

// File: rtl/gc_clear_counter.sv
// Window timer: start loads DEPTH-1, done pulses on the cycle the count reaches zero,
// so a window opened by start lasts DEPTH cycles including the start cycle's successor.
module gc_clear_counter #(
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] cnt_reg;
  logic          running_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      running_reg <= 1'b0;
    end else if (start) begin
      cnt_reg     <= CW'(DEPTH - 1);
      running_reg <= 1'b1;
    end else if (running_reg) begin
      if (cnt_reg == '0) running_reg <= 1'b0;
      else               cnt_reg     <= cnt_reg - 1'b1;
    end
  end

  assign done = running_reg && (cnt_reg == '0);
endmodule

// File: rtl/gc_trap_controller.sv
// Global-control sequencer: arbitrates exceptions, xRET, fences and interrupts and drives
// hold/flush/redirect controls; every output is registered from the next state.
module gc_trap_controller
  import gc_trap_controller_pkg::*;
#(
  parameter int NUM_SRC          = 4,
  parameter int XLEN             = GC_XLEN,
  parameter int ID_W             = GC_ID_W,
  parameter int CODE_W           = GC_CODE_W,
  parameter int INIT_CLEAR_DEPTH = 64,
  parameter int TLB_CLEAR_DEPTH  = 32
) (
  input logic clk,
  input logic rst,
  gc_trap_controller_if.master bus
);
  gc_trap_state_t state_reg, state_next;
  gc_pending_t    pend_reg, pend_next;
  logic [XLEN-1:0] target_reg, target_next, flush_pc;
  logic            trap_take, init_start_reg, init_done, tlb_start, tlb_done, exc_any;
  trap_packet_t    exc_pkt, int_pkt, pkt_sel;

  logic [CODE_W-1:0] exc_code_arr [NUM_SRC];
  logic [XLEN-1:0]   exc_tval_arr [NUM_SRC];
  logic [ID_W-1:0]   exc_id_arr   [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign exc_code_arr[gi] = bus.exc_code[gi*CODE_W +: CODE_W];
      assign exc_tval_arr[gi] = bus.exc_tval[gi*XLEN +: XLEN];
      assign exc_id_arr[gi]   = bus.exc_id[gi*ID_W +: ID_W];
    end
  endgenerate

  assign exc_any = |bus.exc_valid;

  // Scan from the top so the lowest valid index overwrites last and wins.
  always_comb begin
    exc_pkt = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.exc_valid[i]) begin
        exc_pkt.code = exc_code_arr[i];
        exc_pkt.tval = exc_tval_arr[i];
        exc_pkt.id   = exc_id_arr[i];
      end
    end
  end

  always_comb begin
    int_pkt              = '0;
    int_pkt.code         = bus.interrupt_code;
    int_pkt.is_interrupt = 1'b1;
  end

  gc_clear_counter #(.DEPTH(INIT_CLEAR_DEPTH)) u_init_counter (
    .clk(clk), .rst(rst), .start(init_start_reg), .done(init_done)
  );

  assign tlb_start = (state_reg == GC_WAIT_IDLE) && (state_next == GC_TLB_CLEAR);

  gc_clear_counter #(.DEPTH(TLB_CLEAR_DEPTH)) u_tlb_counter (
    .clk(clk), .rst(rst), .start(tlb_start), .done(tlb_done)
  );

  always_comb begin
    state_next  = state_reg;
    pend_next   = pend_reg;
    target_next = target_reg;
    flush_pc    = target_reg;
    trap_take   = 1'b0;
    pkt_sel     = exc_pkt;
    case (state_reg)
      GC_INIT_CLEAR: if (init_done) state_next = GC_IDLE;
      GC_IDLE: begin
        if (exc_any) begin
          state_next = GC_FLUSH;
          trap_take  = 1'b1;
          flush_pc   = bus.trap_vector;
        end else if (bus.ret_req) begin
          state_next = GC_FLUSH;
          flush_pc   = bus.ret_pc;
        end else if (bus.sfence_req || bus.fence_i_req) begin
          state_next  = GC_WAIT_IDLE;
          pend_next   = bus.sfence_req ? PEND_SFENCE : PEND_FENCE_I;
          target_next = bus.sys_pc + XLEN'(4);
        end else if (bus.interrupt_pending) begin
          state_next = GC_WAIT_IDLE;
          pend_next  = PEND_INTERRUPT;
        end
      end
      GC_WAIT_IDLE: begin
        // A pending interrupt is simply dropped here; the level input re-raises it in IDLE.
        if (exc_any) begin
          state_next = GC_FLUSH;
          pend_next  = PEND_NONE;
          trap_take  = 1'b1;
          flush_pc   = bus.trap_vector;
        end else if (bus.pipeline_idle) begin
          case (pend_reg)
            PEND_SFENCE:  state_next = GC_TLB_CLEAR;
            PEND_FENCE_I: state_next = GC_FLUSH;
            PEND_INTERRUPT: begin
              if (bus.interrupt_pending) begin
                state_next = GC_FLUSH;
                trap_take  = 1'b1;
                pkt_sel    = int_pkt;
                flush_pc   = bus.trap_vector;
              end else begin
                state_next = GC_IDLE;
              end
            end
            default: state_next = GC_IDLE;
          endcase
        end
      end
      GC_TLB_CLEAR: if (tlb_done) state_next = GC_FLUSH;
      GC_FLUSH: begin
        state_next = GC_REDIRECT;
        pend_next  = PEND_NONE;
      end
      GC_REDIRECT: state_next = GC_IDLE;
      default:     state_next = GC_INIT_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg             <= GC_INIT_CLEAR;
      pend_reg              <= PEND_NONE;
      target_reg            <= '0;
      init_start_reg        <= 1'b1;
      bus.trap_valid        <= 1'b0;
      bus.trap_is_interrupt <= 1'b0;
      bus.trap_code         <= '0;
      bus.trap_tval         <= '0;
      bus.trap_id           <= '0;
      bus.fetch_hold        <= 1'b1;
      bus.issue_hold        <= 1'b1;
      bus.fetch_flush       <= 1'b0;
      bus.fetch_pc_override <= 1'b0;
      bus.fetch_pc          <= '0;
      bus.init_clear        <= 1'b0;
      bus.tlb_clear         <= 1'b0;
      bus.idle              <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pend_reg       <= pend_next;
      target_reg     <= target_next;
      init_start_reg <= 1'b0;
      bus.trap_valid <= trap_take;
      if (trap_take) begin
        bus.trap_is_interrupt <= pkt_sel.is_interrupt;
        bus.trap_code         <= pkt_sel.code;
        bus.trap_tval         <= pkt_sel.tval;
        bus.trap_id           <= pkt_sel.id;
      end
      if (state_next == GC_FLUSH) bus.fetch_pc <= flush_pc;
      bus.init_clear        <= (state_next == GC_INIT_CLEAR);
      bus.fetch_hold        <= (state_next == GC_INIT_CLEAR);
      bus.issue_hold        <= (state_next != GC_IDLE);
      bus.tlb_clear         <= (state_next == GC_TLB_CLEAR);
      bus.fetch_flush       <= (state_next == GC_FLUSH) || (state_next == GC_REDIRECT);
      bus.fetch_pc_override <= (state_next == GC_REDIRECT);
      bus.idle              <= (state_next == GC_IDLE);
    end
  end
endmodule

// File: tb/tb_gc_trap_controller.sv
// Directed sequence with randomized payloads; expectations come from the event rules
// (priority, latency, window lengths, PC arithmetic) computed inside the bench.
module tb_gc_trap_controller;
  localparam int NS = 4;
  localparam int XL = 32;
  localparam int IW = 3;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gc_trap_controller_if #(.NUM_SRC(NS), .XLEN(XL), .ID_W(IW), .CODE_W(CW)) bus ();

  gc_trap_controller #(
    .NUM_SRC(NS), .XLEN(XL), .ID_W(IW), .CODE_W(CW),
    .INIT_CLEAR_DEPTH(64), .TLB_CLEAR_DEPTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] codes [NS];
  logic [XL-1:0] tvals [NS];
  logic [IW-1:0] ids   [NS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.exc_valid = '0; bus.exc_code = '0; bus.exc_tval = '0; bus.exc_id = '0;
    bus.interrupt_pending = 1'b0; bus.interrupt_code = '0; bus.interrupt_pc = '0;
    bus.pipeline_idle = 1'b0; bus.ret_req = 1'b0; bus.ret_pc = '0;
    bus.fence_i_req = 1'b0; bus.sfence_req = 1'b0; bus.sys_pc = '0; bus.trap_vector = '0;
  endtask

  task automatic randomize_srcs();
    for (int i = 0; i < NS; i++) begin
      codes[i] = CW'($urandom);
      tvals[i] = $urandom;
      ids[i]   = IW'($urandom);
    end
  endtask

  task automatic load_exc(input logic [NS-1:0] mask);
    for (int i = 0; i < NS; i++) begin
      bus.exc_code[i*CW +: CW] = codes[i];
      bus.exc_tval[i*XL +: XL] = tvals[i];
      bus.exc_id[i*IW +: IW]   = ids[i];
    end
    bus.exc_valid = mask;
  endtask

  function automatic int first_src(input logic [NS-1:0] mask);
    for (int i = 0; i < NS; i++) if (mask[i]) return i;
    return 0;
  endfunction

  // Releases reset and measures the init window; random exceptions during it must be ignored.
  task automatic run_init(input string tag);
    int n = 0;
    int traps = 0;
    rst = 1'b0;
    for (int i = 0; i < 200 && !bus.idle; i++) begin
      bus.exc_valid = NS'($urandom);
      step();
      if (bus.init_clear) n++;
      if (bus.trap_valid) traps++;
    end
    bus.exc_valid = '0;
    $display("init %s: init_clear cycles=%0d", tag, n);
    check({tag, "_init_len"}, n, 64);
    check({tag, "_init_traps"}, traps, 0);
    check({tag, "_idle"}, bus.idle, 1);
    check({tag, "_holds"}, {bus.fetch_hold, bus.issue_hold}, 2'b00);
  endtask

  task automatic run_exception(input string tag, input logic [NS-1:0] mask, input logic with_ret);
    logic [XL-1:0] vec;
    int s;
    vec = $urandom;
    s = first_src(mask);
    bus.trap_vector = vec;
    bus.ret_req = with_ret;
    bus.ret_pc = $urandom;
    load_exc(mask);
    step();
    bus.exc_valid = NS'($urandom);
    bus.ret_req = 1'b0;
    bus.trap_vector = ~vec;
    $display("exc %s: mask=%b ret=%0b src=%0d code=%0h id=%0h", tag, mask, with_ret, s, codes[s], ids[s]);
    check({tag, "_trap_valid"}, bus.trap_valid, 1);
    check({tag, "_code"}, bus.trap_code, codes[s]);
    check({tag, "_tval"}, bus.trap_tval, tvals[s]);
    check({tag, "_id"}, bus.trap_id, ids[s]);
    check({tag, "_is_int"}, bus.trap_is_interrupt, 0);
    check({tag, "_flush"}, {bus.fetch_flush, bus.fetch_pc_override}, 2'b10);
    step();
    bus.exc_valid = '0;
    check({tag, "_redirect"}, {bus.trap_valid, bus.fetch_flush, bus.fetch_pc_override}, 3'b011);
    check({tag, "_fetch_pc"}, bus.fetch_pc, vec);
    step();
    check({tag, "_back_idle"}, {bus.idle, bus.issue_hold, bus.trap_valid}, 3'b100);
  endtask

  task automatic run_ret(input string tag);
    logic [XL-1:0] pc;
    pc = $urandom;
    bus.ret_req = 1'b1;
    bus.ret_pc = pc;
    step();
    bus.ret_req = 1'b0;
    bus.ret_pc = ~pc;
    $display("ret %s: ret_pc=%08h", tag, pc);
    check({tag, "_flush_no_trap"}, {bus.fetch_flush, bus.trap_valid}, 2'b10);
    step();
    check({tag, "_override"}, bus.fetch_pc_override, 1);
    check({tag, "_fetch_pc"}, bus.fetch_pc, pc);
    step();
    check({tag, "_idle"}, bus.idle, 1);
  endtask

  task automatic run_fence(input string tag, input logic sfence, input logic [XL-1:0] pc, input int busy);
    logic [XL-1:0] exp_pc;
    int n = 0;
    exp_pc = pc + 32'd4;
    bus.pipeline_idle = 1'b0;
    bus.sys_pc = pc;
    bus.fence_i_req = !sfence;
    bus.sfence_req = sfence;
    step();
    bus.fence_i_req = 1'b0;
    bus.sfence_req = 1'b0;
    bus.sys_pc = $urandom;
    for (int i = 0; i < busy; i++) begin
      check({tag, "_waiting"}, {bus.issue_hold, bus.trap_valid, bus.idle, bus.tlb_clear}, 4'b1000);
      step();
    end
    bus.pipeline_idle = 1'b1;
    if (sfence) begin
      for (int i = 0; i < 100; i++) begin
        step();
        if (bus.tlb_clear) n++;
        if (bus.fetch_flush) break;
      end
      check({tag, "_tlb_len"}, n, 32);
    end else begin
      step();
    end
    $display("fence %s: sfence=%0b sys_pc=%08h expect_pc=%08h tlb_cycles=%0d", tag, sfence, pc, exp_pc, n);
    check({tag, "_flush"}, {bus.fetch_flush, bus.trap_valid, bus.tlb_clear}, 3'b100);
    step();
    check({tag, "_override"}, bus.fetch_pc_override, 1);
    check({tag, "_fetch_pc"}, bus.fetch_pc, exp_pc);
    step();
    check({tag, "_idle"}, bus.idle, 1);
  endtask

  initial begin
    logic [XL-1:0] vec;
    logic [CW-1:0] icode;
    int found;

    quiet();
    rst = 1'b1;
    step(3);
    check("rst_holds", {bus.fetch_hold, bus.issue_hold}, 2'b11);
    check("rst_flags", {bus.init_clear, bus.tlb_clear, bus.idle, bus.trap_valid,
                        bus.fetch_flush, bus.fetch_pc_override, bus.trap_is_interrupt}, 7'b0);
    check("rst_fetch_pc", bus.fetch_pc, 0);
    check("rst_trap_code", bus.trap_code, 0);
    run_init("boot");

    randomize_srcs();
    codes[1] = 5'd5;
    codes[3] = 5'd2;
    run_exception("exc1010", 4'b1010, 1'b0);

    for (int t = 0; t < 8; t++) begin
      randomize_srcs();
      run_exception("exc_rand", NS'($urandom_range(1, 15)), 1'($urandom));
    end

    run_ret("ret0");
    run_ret("ret1");

    run_fence("fencei_100", 1'b0, 32'h0000_0100, 5);
    run_fence("fencei_wrap", 1'b0, 32'hFFFF_FFFC, 0);
    run_fence("fencei_rand", 1'b0, $urandom, $urandom_range(0, 6));

    // Interrupt waiting for idle is preempted by an exception, then taken afterwards.
    icode = CW'($urandom);
    vec = $urandom;
    bus.trap_vector = vec;
    bus.interrupt_code = icode;
    bus.interrupt_pending = 1'b1;
    bus.pipeline_idle = 1'b0;
    step();
    check("irq_wait", {bus.idle, bus.issue_hold, bus.trap_valid}, 3'b010);
    randomize_srcs();
    load_exc(4'b0100);
    step();
    bus.exc_valid = '0;
    $display("irq preempt: exc src=2 code=%0h, irq code=%0h", codes[2], icode);
    check("irq_pre_exc_valid", bus.trap_valid, 1);
    check("irq_pre_exc_code", bus.trap_code, codes[2]);
    check("irq_pre_exc_id", bus.trap_id, ids[2]);
    check("irq_pre_exc_is_int", bus.trap_is_interrupt, 0);
    step();
    check("irq_pre_exc_pc", bus.fetch_pc, vec);
    bus.pipeline_idle = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.trap_valid) begin
        found = 1;
        break;
      end
      step();
    end
    check("irq_trap_seen", found, 1);
    check("irq_is_int", bus.trap_is_interrupt, 1);
    check("irq_code", bus.trap_code, icode);
    check("irq_tval", bus.trap_tval, 0);
    bus.interrupt_pending = 1'b0;
    step();
    check("irq_redirect", {bus.fetch_pc_override, bus.trap_valid}, 2'b10);
    check("irq_fetch_pc", bus.fetch_pc, vec);
    step();
    check("irq_idle", bus.idle, 1);

    // Interrupt withdrawn before the pipeline drains: back to IDLE with nothing taken.
    bus.interrupt_pending = 1'b1;
    bus.pipeline_idle = 1'b0;
    step();
    bus.interrupt_pending = 1'b0;
    bus.pipeline_idle = 1'b1;
    step();
    $display("irq drop: idle=%0b trap_valid=%0b", bus.idle, bus.trap_valid);
    check("irq_drop", {bus.idle, bus.trap_valid, bus.fetch_flush}, 3'b100);

    run_fence("sfence", 1'b1, $urandom, 3);

    // Reset in the middle of a TLB window restarts the init sequence.
    bus.sys_pc = $urandom;
    bus.sfence_req = 1'b1;
    bus.pipeline_idle = 1'b1;
    step();
    bus.sfence_req = 1'b0;
    step(10);
    check("sfence_rst_tlb_on", bus.tlb_clear, 1);
    rst = 1'b1;
    step();
    $display("sfence reset: tlb_clear=%0b init_clear=%0b", bus.tlb_clear, bus.init_clear);
    check("sfence_rst_tlb_off", {bus.tlb_clear, bus.init_clear, bus.idle}, 3'b000);
    check("sfence_rst_holds", {bus.fetch_hold, bus.issue_hold}, 2'b11);
    step();
    run_init("reinit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/gc_trap_controller.md
Name: gc_trap_controller

Overview:
Parametrised next-generation global-control sequencer for the Taiga core.
- Arbitrates NUM_SRC exception sources, external interrupts, xRET, FENCE.I and SFENCE.VMA.
- Drives fetch/issue hold, flush and PC-redirect controls, and sequences reset-time and TLB clear windows.
- Sits between decode/execute exception reporters and fetch, and hands a single trap packet to csr_regs.

Parameters:
NUM_SRC, 4, number of exception sources; index 0 = highest priority
XLEN, 32, PC/tval width
ID_W, 3, instruction id width
CODE_W, 5, exception/interrupt code width
INIT_CLEAR_DEPTH, 64, cycles of init_clear after reset
TLB_CLEAR_DEPTH, 32, cycles of tlb_clear per SFENCE

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
exc_valid  in  NUM_SRC  per-source exception strobe
exc_code  in  NUM_SRC*CODE_W  packed codes, source i at [i*CODE_W+:CODE_W]
exc_tval  in  NUM_SRC*XLEN  packed tval
exc_id  in  NUM_SRC*ID_W  packed instruction ids
interrupt_pending  in  1  enabled, pending interrupt from CSRs
interrupt_code  in  CODE_W  interrupt cause
interrupt_pc  in  XLEN  resume PC for interrupt
pipeline_idle  in  1  no instruction in flight, LS unit empty
ret_req  in  1  xRET issued (one cycle)
ret_pc  in  XLEN  mepc/sepc target
fence_i_req  in  1  FENCE.I issued (one cycle)
sfence_req  in  1  SFENCE.VMA issued (one cycle)
sys_pc  in  XLEN  PC of the fence instruction
trap_vector  in  XLEN  handler address from CSRs
trap_valid  out  1  one-cycle trap commit to CSRs
trap_is_interrupt  out  1  trap is interrupt
trap_code  out  CODE_W  cause
trap_tval  out  XLEN  tval (0 for interrupts)
trap_id  out  ID_W  id of faulting instruction
fetch_hold  out  1  hold fetch
issue_hold  out  1  hold issue
fetch_flush  out  1  flush front end
fetch_pc_override  out  1  fetch takes fetch_pc
fetch_pc  out  XLEN  redirect target
init_clear  out  1  id/TLB memories clearing
tlb_clear  out  1  TLB invalidate window
idle  out  1  state == IDLE

Behaviour:
- All outputs are registered. Reset values: all 1-bit outputs 0 except fetch_hold=1 and issue_hold=1. fetch_pc=0, trap_* = 0.
- Reset mid-operation abandons any pending event and re-enters INIT_CLEAR on the first cycle after rst deasserts.
- States are INIT_CLEAR, IDLE, WAIT_IDLE, TLB_CLEAR, FLUSH and REDIRECT.
- INIT_CLEAR: init_clear, fetch_hold and issue_hold are asserted for exactly INIT_CLEAR_DEPTH cycles, then the block enters IDLE.
- IDLE priority, in decreasing order:
  - Any exc_valid: latch the lowest-index valid source. Next state FLUSH. fetch_pc = trap_vector.
  - ret_req: next state FLUSH. fetch_pc = ret_pc.
  - fence_i_req or sfence_req: latch type and sys_pc+4 (mod 2^XLEN). Next state WAIT_IDLE.
  - interrupt_pending: next state WAIT_IDLE with interrupt marked.
- WAIT_IDLE:
  - issue_hold is asserted.
  - If exc_valid arrives, the exception preempts: a pending fence is discarded, an interrupt stays pending and is re-evaluated in IDLE, and the block goes to FLUSH with the exception.
  - Otherwise, when pipeline_idle:
    - sfence goes to TLB_CLEAR.
    - fence_i goes to FLUSH.
    - interrupt goes to FLUSH with fetch_pc=trap_vector, trap_code=interrupt_code, trap_tval=0, trap_is_interrupt=1. If interrupt_pending has dropped, the block returns to IDLE with no action.
- TLB_CLEAR: tlb_clear and issue_hold are asserted for TLB_CLEAR_DEPTH cycles, then the block goes to FLUSH.
- FLUSH (1 cycle): fetch_flush=1 and issue_hold=1. trap_valid=1 in this cycle only, and only for exceptions/interrupts.
- REDIRECT (1 cycle): fetch_flush=1, fetch_pc_override=1, issue_hold=1, then IDLE.
- Latency: exception in cycle N gives trap_valid in N+1 and fetch_pc_override in N+2.
- exc_valid during FLUSH, REDIRECT, TLB_CLEAR or INIT_CLEAR is ignored; these exceptions come from squashed younger instructions.
- Simultaneous ret_req and exc_valid: the exception wins and the ret is dropped.
- idle=1 only in IDLE. fetch_hold is asserted only during INIT_CLEAR.

Decomposition:
- Add gc_trap_state_t and trap_packet_t (code, tval, id, is_interrupt) to taiga_types.
- One sub-module: gc_clear_counter (DEPTH parameter, start/done, one-hot shift or binary). It is instantiated twice, for the init window and the TLB window.

Test Plan:
- Reset: rst high for 3 cycles then released -> init_clear high for exactly 64 cycles, then idle=1, issue_hold=0.
- exc_valid=4'b1010, codes src1=5, src3=2 -> trap_valid next cycle with trap_code=5, trap_id=src1 id. Next cycle fetch_pc_override=1, fetch_pc=trap_vector.
- fence_i_req with sys_pc=0x100 and pipeline_idle low for 5 cycles -> issue_hold throughout, no trap_valid, fetch_pc=0x104 two cycles after pipeline_idle rises.
- Interrupt pending in WAIT_IDLE when exc_valid[2] arrives -> exception trap taken first; interrupt trap (trap_is_interrupt=1, tval=0) follows once pipeline_idle is high.
- sfence_req -> tlb_clear high for exactly 32 cycles after pipeline_idle, then flush and redirect to sys_pc+4. rst mid-window -> tlb_clear drops and the INIT_CLEAR sequence restarts.
- sys_pc=0xFFFFFFFC FENCE.I -> fetch_pc=0x00000000 (wrap).
